// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Holds the fetch FSM states, the bubble encoding and the opcode width.
package if_stage_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    localparam int unsigned OPCODE_W     = 7;
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// The skid entry catches a fetch that completes while decode is stalled.
module ifid_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kill,
    input  logic        stall,
    input  logic        capture,
    input  logic [31:0] cap_pc,
    input  logic [31:0] cap_instr,
    output logic        skid_valid,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
);

    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (kill) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (stall) begin
            if (capture) begin
                skid_valid <= 1'b1;
                skid_pc    <= cap_pc;
                skid_instr <= cap_instr;
            end
        end else if (skid_valid) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= skid_pc;
            ifid_instr <= skid_instr;
            skid_valid <= 1'b0;
        end else if (capture) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= cap_pc;
            ifid_instr <= cap_instr;
        end else begin
            // bubble keeps the previous pc
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch FSM, program counter and redirect handling.
// Redirects that arrive mid-request wait in DRAIN until the old request completes.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_ready,
    output logic                ifid_valid,
    output logic [31:0]         ifid_pc,
    output logic [31:0]         ifid_instr,
    output logic [OPCODE_W-1:0] ifid_opcode
);

    if_state_e   state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pending_pc, pending_n;
    logic [31:0] target;
    logic        skid_valid;
    logic        fetch_done;
    logic        capture;
    logic        kill;

    assign imem_req    = ((state == FETCH) && !skid_valid) || (state == DRAIN);
    assign imem_addr   = pc;
    assign fetch_done  = imem_req && imem_ready;
    assign target      = align_word(redirect_pc);
    assign kill        = redirect_valid || flush;
    // data is only usable from FETCH and never in a redirect or flush cycle
    assign capture     = (state == FETCH) && fetch_done && !kill;
    assign ifid_opcode = ifid_instr[OPCODE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pending_pc <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pending_pc <= pending_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pending_n = pending_pc;
        case (state)
            BOOT: begin
                state_n = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    if (imem_req && !imem_ready) begin
                        pending_n = target;
                        state_n   = DRAIN;
                    end else begin
                        pc_n = target;
                    end
                end else if (fetch_done) begin
                    pc_n = pc + 32'd4;
                end
            end
            DRAIN: begin
                if (redirect_valid) pending_n = target;
                if (imem_ready) begin
                    pc_n    = redirect_valid ? target : pending_pc;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .kill      (kill),
        .stall     (stall),
        .capture   (capture),
        .cap_pc    (pc),
        .cap_instr (imem_rdata),
        .skid_valid(skid_valid),
        .ifid_valid(ifid_valid),
        .ifid_pc   (ifid_pc),
        .ifid_instr(ifid_instr)
    );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vectors, a behavioural model
// checked every cycle, and literal expectations for the key scenarios.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [6:0]  ifid_opcode;

    int tests = 0;
    int fails = 0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_opcode   (ifid_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory contents: every word is distinct and derived from its address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[26:2], 7'b0110011};
    endfunction

    assign imem_rdata = mem(imem_addr);

    // behavioural model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        skidq[$];
    bit          booting;
    bit          draining;
    logic [31:0] m_pc;
    logic [31:0] m_pending;
    logic        m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_instr;

    task automatic m_reset();
        booting   = 1'b1;
        draining  = 1'b0;
        m_pc      = 32'h0;
        m_pending = 32'h0;
        skidq.delete();
        m_valid   = 1'b0;
        m_ifpc    = 32'h0;
        m_instr   = NOP;
    endtask

    function automatic logic m_req();
        return !booting && (draining || skidq.size() == 0);
    endfunction

    task automatic model_update();
        logic        req;
        logic        done;
        logic [31:0] tgt;
        ent_t        e;
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (booting) begin
            booting = 1'b0;
            return;
        end
        req  = m_req();
        done = req && imem_ready;
        tgt  = {redirect_pc[31:2], 2'b00};
        if (redirect_valid || flush) begin
            m_valid = 1'b0;
            m_instr = NOP;
            skidq.delete();
        end else if (stall) begin
            if (done && !draining) begin
                e.pc    = m_pc;
                e.instr = mem(m_pc);
                skidq.push_back(e);
            end
        end else if (skidq.size() != 0) begin
            e       = skidq.pop_front();
            m_valid = 1'b1;
            m_ifpc  = e.pc;
            m_instr = e.instr;
        end else if (done && !draining) begin
            m_valid = 1'b1;
            m_ifpc  = m_pc;
            m_instr = mem(m_pc);
        end else begin
            m_valid = 1'b0;
            m_instr = NOP;
        end
        if (draining) begin
            if (redirect_valid) m_pending = tgt;
            if (imem_ready) begin
                m_pc     = redirect_valid ? tgt : m_pending;
                draining = 1'b0;
            end
        end else if (redirect_valid) begin
            if (req && !imem_ready) begin
                m_pending = tgt;
                draining  = 1'b1;
            end else begin
                m_pc = tgt;
            end
        end else if (done) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    // one cycle: drive, sample mid-cycle against the model, advance the model at the edge
    task automatic step(input logic st, input logic fl, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        stall          = st;
        flush          = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ready     = rdy;
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = ifid_valid;
        s_pc    = ifid_pc;
        s_instr = ifid_instr;
        check("model_req", {31'b0, s_req}, {31'b0, m_req()});
        check("model_addr", s_addr, m_pc);
        check("model_valid", {31'b0, s_valid}, {31'b0, m_valid});
        check("model_ifpc", s_pc, m_ifpc);
        check("model_instr", s_instr, m_instr);
        check("model_opcode", {25'b0, ifid_opcode}, {25'b0, m_instr[6:0]});
        if (s_valid) check("no_stale", s_instr, mem(s_pc));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic go(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_ready = 1'b1;
        m_reset();

        go(1'b1);
        go(1'b1);
        rst_n = 1'b1;

        // reset release with ready held high
        go(1'b1); check("boot_req", {31'b0, s_req}, 32'd0);
        go(1'b1); check("f0_addr", s_addr, 32'h0); check("f0_req", {31'b0, s_req}, 32'd1);
        go(1'b1); check("f1_addr", s_addr, 32'h4); check("f1_ifpc", s_pc, 32'h0);
                  check("f1_valid", {31'b0, s_valid}, 32'd1);
        go(1'b1); check("f2_addr", s_addr, 32'h8); check("f2_ifpc", s_pc, 32'h4);
        go(1'b1); check("f3_addr", s_addr, 32'hC);

        // three not-ready cycles at 0x10
        go(1'b0); check("wait0_addr", s_addr, 32'h10);
        go(1'b0); check("wait1_addr", s_addr, 32'h10); check("bubble1_instr", s_instr, NOP);
                  check("bubble1_valid", {31'b0, s_valid}, 32'd0);
        go(1'b0); check("wait2_addr", s_addr, 32'h10); check("bubble2_instr", s_instr, NOP);
        go(1'b1); check("wait3_addr", s_addr, 32'h10); check("bubble3_valid", {31'b0, s_valid}, 32'd0);

        // two stall cycles with ready high, then release
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("st0_ifpc", s_pc, 32'h10); check("st0_instr", s_instr, mem(32'h10));
        check("st0_addr", s_addr, 32'h14);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("st1_req", {31'b0, s_req}, 32'd0); check("st1_ifpc", s_pc, 32'h10);
        go(1'b1); check("rel_req", {31'b0, s_req}, 32'd0); check("rel_ifpc", s_pc, 32'h10);
        go(1'b1); check("skid_ifpc", s_pc, 32'h14); check("skid_valid", {31'b0, s_valid}, 32'd1);
                  check("resume_addr", s_addr, 32'h18);

        // redirect to 0x103 while the request at 0x1C is unready
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0); check("rd_addr", s_addr, 32'h1C);
        go(1'b0); check("drain0_addr", s_addr, 32'h1C); check("drain0_valid", {31'b0, s_valid}, 32'd0);
        go(1'b1); check("drain1_addr", s_addr, 32'h1C); check("drain1_valid", {31'b0, s_valid}, 32'd0);
        go(1'b1); check("tgt_addr", s_addr, 32'h100); check("tgt_valid", {31'b0, s_valid}, 32'd0);
        go(1'b1); check("tgt_ifpc", s_pc, 32'h100); check("tgt_ifvalid", {31'b0, s_valid}, 32'd1);

        // redirect coinciding with ready, then wrap past the top of memory
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        go(1'b1); check("wrap_addr", s_addr, 32'hFFFF_FFFC); check("wrap_drop", {31'b0, s_valid}, 32'd0);
        go(1'b1); check("wrap_next", s_addr, 32'h0); check("wrap_ifpc", s_pc, 32'hFFFF_FFFC);

        // flush beats stall; flush empties a full skid
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1); check("fl_addr", s_addr, 32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); check("fl_valid", {31'b0, s_valid}, 32'd0);
        check("fl_pc_adv", s_addr, 32'h8);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); check("flskid_req", {31'b0, s_req}, 32'd0);
        go(1'b1); check("flskid_addr", s_addr, 32'hC); check("flskid_valid", {31'b0, s_valid}, 32'd0);

        // reset asserted in the middle of DRAIN
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        go(1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", {31'b0, ifid_valid}, 32'd0);
        check("arst_ifpc", ifid_pc, 32'h0);
        check("arst_instr", ifid_instr, NOP);
        check("arst_opcode", {25'b0, ifid_opcode}, 32'h13);
        m_reset();
        go(1'b1);
        go(1'b1);
        rst_n = 1'b1;
        go(1'b1); check("rb_req", {31'b0, s_req}, 32'd0);
        go(1'b1); check("rf_addr", s_addr, 32'h0); check("rf_req", {31'b0, s_req}, 32'd1);
        go(1'b1); check("rf_ifpc", s_pc, 32'h0); check("rf_valid", {31'b0, s_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble encoding.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stall  input  1  decode/hazard unit holds IF/ID.
REQ-006 flush  input  1  kill current IF/ID contents.
REQ-007 redirect_valid  input  1  taken branch/jal/jalr from EX.
REQ-008 redirect_pc  input  32  redirect target.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  fetch address, word aligned.
REQ-011 imem_rdata  input  32  fetched instruction, valid when imem_ready=1.
REQ-012 imem_ready  input  1  request completes this cycle.
REQ-013 ifid_valid  output  1  IF/ID holds a live instruction.
REQ-014 ifid_pc  output  32  PC of IF/ID instruction.
REQ-015 ifid_instr  output  32  IF/ID instruction, to decode/immediate generation.
REQ-016 ifid_opcode  output  7  equals ifid_instr[6:0].

Function
REQ-017 FSM states SHALL be BOOT, FETCH and DRAIN.
REQ-018 BOOT: imem_req=0; the FSM SHALL move to FETCH after exactly one cycle.
REQ-019 FETCH: imem_req=1 unless skid_valid=1; imem_addr=pc.
REQ-020 imem_addr SHALL be held stable while imem_req=1 and imem_ready=0.
REQ-021 In FETCH with imem_ready=1 and stall=0, the next edge SHALL load IF/ID with {valid=1, pc, imem_rdata} and set pc to pc+4.
REQ-022 pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-023 In FETCH with imem_ready=0 and stall=0, IF/ID SHALL load a bubble {valid=0, pc unchanged, NOP_INSTR}.
REQ-024 While stall=1, the IF/ID register SHALL be held.
REQ-025 While stall=1, imem_ready=1 SHALL capture {pc, imem_rdata} into a one-entry skid buffer, set skid_valid and advance pc.
REQ-026 When stall falls with skid_valid=1, IF/ID SHALL load the skid entry, skid_valid SHALL clear, and fetching SHALL resume the next cycle.
REQ-027 Priority SHALL be redirect > flush > stall > normal advance.
REQ-028 flush=1 SHALL load a bubble into IF/ID and clear skid_valid, even when stall=1; pc and fetch progress SHALL be unaffected.
REQ-029 redirect_valid=1 with no outstanding unready request SHALL load a bubble into IF/ID, clear the skid, and set pc to {redirect_pc[31:2],2'b00}.
REQ-030 Redirect while imem_req=1 and imem_ready=0 SHALL store the target in pending_pc and enter DRAIN.
REQ-031 DRAIN: keep imem_addr on the old pc until imem_ready; a further redirect SHALL overwrite pending_pc.
REQ-032 DRAIN with imem_ready=1 SHALL discard imem_rdata, set pc to pending_pc and return to FETCH.
REQ-033 A redirect in the same cycle as imem_ready=1 SHALL discard the data and redirect without entering DRAIN.
REQ-034 ifid_valid=1 SHALL never be produced from data fetched before a redirect.

Reset
REQ-035 Asserting rst_n=0 at any time, including mid-DRAIN, SHALL immediately force: state BOOT, pc=RESET_PC, pending_pc=0, skid_valid=0, imem_req=0, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR.
REQ-036 No imem handshake SHALL start before the BOOT cycle following reset release.

Structure
REQ-037 The state encoding, NOP_INSTR and the opcode width constant SHALL live in the shared pipeline package.
REQ-038 The IF/ID register plus skid buffer SHALL be one sub-module named ifid_reg; the FSM and pc logic stay in if_stage.

Verification
REQ-039 Reset release with imem_ready=1 always -> BOOT one cycle, then imem_addr 0,4,8; ifid_pc 0,4 with ifid_valid=1.
REQ-040 imem_ready low 3 cycles at pc=0x10 -> imem_addr held at 0x10; three bubbles carrying NOP 0x00000013; then the instruction at 0x10.
REQ-041 stall for 2 cycles with imem_ready=1 -> IF/ID held, skid holds 0x14; imem_req=0 in cycle 2; on release IF/ID shows 0x14, next fetch 0x18.
REQ-042 redirect_valid to 0x103 while imem_ready=0 -> DRAIN, addr held; on ready the data is dropped; next imem_addr=0x100 and no stale ifid_valid.
REQ-043 pc=0xFFFF_FFFC fetch -> next imem_addr 0x0000_0000.
REQ-044 rst_n pulsed low during DRAIN -> all outputs at reset values asynchronously; fetch restarts at RESET_PC.
